// File: rtl/input_conditioner.sv
// Push-button / slide-switch front end: synchronizes raw pins, debounces the button,
// and turns each accepted press into a sticky Enter flag plus a wrapping press counter.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_n,
  input  logic [9:0] sw_raw,
  input  logic       ack,
  output logic [9:0] switches,
  output logic       Enter,
  output logic       pressed,
  output logic [7:0] press_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0]       btn_sync_p0;
  logic [SYNC_STAGES-1:0][9:0]  sw_sync_p0;
  logic [CNT_W-1:0]             cnt_p1;
  logic                         btn_s;
  logic                         press_evt;

  assign btn_s    = btn_sync_p0[SYNC_STAGES-1];
  assign switches = sw_sync_p0[SYNC_STAGES-1];

  // A press is the one edge where the debounced level flips from released to held.
  assign press_evt = btn_s && !pressed && (cnt_p1 == CNT_MAX);

  // Stage p0: synchronizer chains; the button chain idles at "released" (0).
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_sync_p0 <= '0;
      sw_sync_p0  <= '0;
    end else begin
      btn_sync_p0 <= {btn_sync_p0[SYNC_STAGES-2:0], ~key_n};
      sw_sync_p0  <= {sw_sync_p0[SYNC_STAGES-2:0], sw_raw};
    end
  end

  // Stage p1: debounce; any sample agreeing with the accepted level restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_p1  <= '0;
      pressed <= 1'b0;
    end else if (btn_s == pressed) begin
      cnt_p1 <= '0;
    end else if (cnt_p1 == CNT_MAX) begin
      pressed <= btn_s;
      cnt_p1  <= '0;
    end else begin
      cnt_p1 <= cnt_p1 + CNT_W'(1);
    end
  end

  // Stage p2: sticky flag and counter; a press on the same edge as ack wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      Enter       <= 1'b0;
      press_count <= '0;
    end else if (press_evt) begin
      Enter       <= 1'b1;
      press_count <= press_count + 8'd1;
    end else if (ack) begin
      Enter <= 1'b0;
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios plus random stimulus, all checked
// against a queue-based reference model of the synchronize/debounce/flag behaviour.
module tb_input_conditioner;

  localparam int DC = 4;
  localparam int SS = 2;
  localparam int CW = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_n;
  logic [9:0] sw_raw;
  logic       ack;
  logic [9:0] switches;
  logic       Enter;
  logic       pressed;
  logic [7:0] press_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  input_conditioner #(
    .DEBOUNCE_CYCLES(DC),
    .SYNC_STAGES    (SS),
    .CNT_W          (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_n      (key_n),
    .sw_raw     (sw_raw),
    .ack        (ack),
    .switches   (switches),
    .Enter      (Enter),
    .pressed    (pressed),
    .press_count(press_count)
  );

  // Reference model: delay lines as queues, debounce as a run length of
  // consecutive samples disagreeing with the accepted level.
  bit         m_btn_q[$];
  bit [9:0]   m_sw_q[$];
  bit         m_pressed = 1'b0;
  bit         m_enter   = 1'b0;
  int         m_run     = 0;
  bit [7:0]   m_count   = '0;
  bit [9:0]   m_switches = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_btn_q = {};
      m_sw_q  = {};
      for (int i = 0; i < SS; i++) begin
        m_btn_q.push_back(1'b0);
        m_sw_q.push_back(10'h000);
      end
      m_pressed = 1'b0;
      m_enter   = 1'b0;
      m_run     = 0;
      m_count   = '0;
    end else begin
      bit ev;
      bit seen;
      ev   = 1'b0;
      seen = m_btn_q[0];
      if (seen != m_pressed) begin
        m_run++;
        if (m_run == DC) begin
          m_pressed = seen;
          m_run     = 0;
          ev        = seen;
        end
      end else begin
        m_run = 0;
      end
      if (ev) begin
        m_enter = 1'b1;
        m_count++;
      end else if (ack) begin
        m_enter = 1'b0;
      end
      m_btn_q.push_back(~key_n);
      void'(m_btn_q.pop_front());
      m_sw_q.push_back(sw_raw);
      void'(m_sw_q.pop_front());
    end
    m_switches = m_sw_q[0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".switches"},    32'(switches),    32'(m_switches));
    chk({tag, ".Enter"},       32'(Enter),       32'(m_enter));
    chk({tag, ".pressed"},     32'(pressed),     32'(m_pressed));
    chk({tag, ".press_count"}, 32'(press_count), 32'(m_count));
  endtask

  initial begin
    reset  = 1'b1;
    key_n  = 1'b1;
    ack    = 1'b0;
    sw_raw = '0;
    @(negedge clk);

    // Reset with the button held and all switches up
    key_n  = 1'b0;
    sw_raw = 10'h3FF;
    tick("rst");
    tick("rst");
    chk("rst_switches", 32'(switches), 32'h0);
    chk("rst_enter",    32'(Enter),    32'h0);
    chk("rst_pressed",  32'(pressed),  32'h0);
    chk("rst_count",    32'(press_count), 32'h0);
    reset = 1'b0;
    tick("sw1");
    chk("sw_lat1", 32'(switches), 32'h0);
    tick("sw2");
    chk("sw_lat2", 32'(switches), 32'h3FF);
    repeat (3) tick("deb");
    chk("press_early", 32'(pressed), 32'h0);
    tick("deb6");
    chk("press_on6_pressed", 32'(pressed), 32'h1);
    chk("press_on6_enter",   32'(Enter),   32'h1);
    chk("press_on6_count",   32'(press_count), 32'h1);

    // Ack clears Enter; ack while clear does nothing
    ack = 1'b1;
    tick("ack");
    ack = 1'b0;
    chk("ack_enter",   32'(Enter),   32'h0);
    chk("ack_pressed", 32'(pressed), 32'h1);
    ack = 1'b1;
    tick("ack_idle");
    ack = 1'b0;
    chk("ack_idle_enter", 32'(Enter), 32'h0);
    chk("ack_idle_count", 32'(press_count), 32'h1);

    // Holding produces no further events
    repeat (50) tick("hold");
    chk("hold_count", 32'(press_count), 32'h1);
    chk("hold_enter", 32'(Enter), 32'h0);
    key_n = 1'b1;
    repeat (8) tick("release");
    chk("release_pressed", 32'(pressed), 32'h0);
    chk("release_count",   32'(press_count), 32'h1);

    // Clean press
    key_n = 1'b0;
    repeat (5) tick("clean");
    chk("clean_early_enter", 32'(Enter), 32'h0);
    tick("clean6");
    chk("clean_enter", 32'(Enter), 32'h1);
    chk("clean_count", 32'(press_count), 32'h2);
    repeat (50) tick("clean_hold");
    chk("clean_hold_count", 32'(press_count), 32'h2);
    ack = 1'b1;
    tick("clean_ack");
    ack   = 1'b0;
    key_n = 1'b1;
    repeat (8) tick("clean_rel");

    // Bounce: 0,1,0,1 for two cycles each, then settle low
    for (int i = 0; i < 4; i++) begin
      key_n = (i % 2) != 0;
      repeat (2) tick("bounce");
    end
    chk("bounce_count", 32'(press_count), 32'h2);
    key_n = 1'b0;
    repeat (5) tick("settle");
    chk("settle_early", 32'(press_count), 32'h2);
    tick("settle6");
    chk("settle_count", 32'(press_count), 32'h3);
    repeat (20) tick("settle_hold");
    chk("settle_hold_count", 32'(press_count), 32'h3);
    ack = 1'b1;
    tick("settle_ack");
    ack   = 1'b0;
    key_n = 1'b1;
    repeat (8) tick("settle_rel");

    // Ack on the same edge as a press event: set wins
    key_n = 1'b0;
    repeat (5) tick("simul");
    ack = 1'b1;
    tick("simul6");
    ack = 1'b0;
    chk("simul_enter", 32'(Enter), 32'h1);
    chk("simul_count", 32'(press_count), 32'h4);
    key_n = 1'b1;
    ack   = 1'b1;
    tick("simul_ack");
    ack = 1'b0;
    repeat (8) tick("simul_rel");
    chk("simul_rel_enter", 32'(Enter), 32'h0);

    // 256 presses from reset wrap the counter back to 0
    reset = 1'b1;
    tick("wrap_rst");
    reset = 1'b0;
    chk("wrap_start", 32'(press_count), 32'h0);
    for (int p = 0; p < 256; p++) begin
      key_n = 1'b0;
      repeat (6) tick("wrap_press");
      if (p == 254) chk("wrap_255", 32'(press_count), 32'hFF);
      key_n = 1'b1;
      repeat (6) tick("wrap_rel");
    end
    chk("wrap_zero",  32'(press_count), 32'h0);
    chk("wrap_enter", 32'(Enter), 32'h1);

    // Reset in the middle of a debounce discards it
    key_n = 1'b0;
    repeat (5) tick("mid");
    chk("mid_pressed", 32'(pressed), 32'h0);
    reset = 1'b1;
    tick("mid_rst");
    chk("mid_rst_enter", 32'(Enter), 32'h0);
    chk("mid_rst_count", 32'(press_count), 32'h0);
    reset = 1'b0;
    repeat (5) tick("mid_after");
    chk("mid_after_pressed", 32'(pressed), 32'h0);
    tick("mid_after6");
    chk("mid_after6_pressed", 32'(pressed), 32'h1);
    chk("mid_after6_count",   32'(press_count), 32'h1);

    // Random bouncing button, random acks, random switches
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) key_n = ~key_n;
      ack    = ($urandom_range(0, 4) == 0);
      sw_raw = 10'($urandom);
      tick("rand");
    end
    ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
